// File: rtl/gray_count_tracker.sv
// Purpose : consumes a free-running Gray counter from a possibly unrelated clock; synchronizes,
//           decodes to binary, validates +1 steps and keeps a wider extended count across wraps.
// Latency : SYNC_STAGES edges from first-flop capture to bin_out/ext_count/pulses; no backpressure.
// Ports   : clk, resetn (sync, active-low), gray_in -> bin_out, ext_count, step_valid, wrap_pulse,
//           err_pulse, err_count (saturating), locked.
module gray_count_tracker #(
    parameter int DATA_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EXT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] gray_in,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic [EXT_WIDTH-1:0]  ext_count,
    output logic                  step_valid,
    output logic                  wrap_pulse,
    output logic                  err_pulse,
    output logic [7:0]            err_count,
    output logic                  locked
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam logic [2:0]            FILL_LAST = 3'(SYNC_STAGES - 1);
    localparam logic [DATA_WIDTH-1:0] BIN_ONE   = 1;
    localparam logic [EXT_WIDTH-1:0]  EXT_ONE   = 1;

    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain, nothing between stages, so each stage gets a full cycle to settle.
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] gray_s;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_s = sync_q[SYNC_STAGES-1];

    state_t                state_q, state_d;
    logic [2:0]            fill_cnt, fill_d;
    logic [DATA_WIDTH-1:0] prev_g, prev_g_d;
    logic [DATA_WIDTH-1:0] bin_d;
    logic [EXT_WIDTH-1:0]  ext_d;
    logic                  step_d, wrap_d, errp_d, locked_d;
    logic [7:0]            errc_d;

    logic [DATA_WIDTH-1:0] cur_bin, prev_bin, delta;

    assign cur_bin  = gray2bin(gray_s);
    assign prev_bin = gray2bin(prev_g);
    // Modulo-2^DATA_WIDTH difference: 1 is the only legal change, so the 15->0 step is legal too.
    assign delta    = cur_bin - prev_bin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= FILL;
            fill_cnt   <= '0;
            prev_g     <= '0;
            bin_out    <= '0;
            ext_count  <= '0;
            step_valid <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt   <= fill_d;
            prev_g     <= prev_g_d;
            bin_out    <= bin_d;
            ext_count  <= ext_d;
            step_valid <= step_d;
            wrap_pulse <= wrap_d;
            err_pulse  <= errp_d;
            err_count  <= errc_d;
            locked     <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_cnt;
        prev_g_d = prev_g;
        bin_d    = bin_out;
        ext_d    = ext_count;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        errp_d   = 1'b0;
        errc_d   = err_count;
        locked_d = locked;

        case (state_q)
            // Wait until the synchronizer holds only post-reset samples of gray_in.
            FILL: begin
                if (fill_cnt == FILL_LAST) begin
                    state_d = ACQUIRE;
                end else begin
                    fill_d = fill_cnt + 3'd1;
                end
            end
            ACQUIRE: begin
                prev_g_d = gray_s;
                bin_d    = cur_bin;
                ext_d    = {{(EXT_WIDTH-DATA_WIDTH){1'b0}}, cur_bin};
                locked_d = 1'b1;
                state_d  = TRACK;
            end
            TRACK: begin
                if (delta == BIN_ONE) begin
                    prev_g_d = gray_s;
                    bin_d    = cur_bin;
                    ext_d    = ext_count + EXT_ONE;
                    step_d   = 1'b1;
                    wrap_d   = &prev_bin;
                end else if (delta != '0) begin
                    // Resync onto the new value so one glitch costs one error, not a stream of them.
                    prev_g_d = gray_s;
                    bin_d    = cur_bin;
                    errp_d   = 1'b1;
                    errc_d   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_gray_count_tracker.sv
module tb_gray_count_tracker;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  gray_in = 4'h0;
    logic [3:0]  bin_out;
    logic [15:0] ext_count;
    logic        step_valid, wrap_pulse, err_pulse, locked;
    logic [7:0]  err_count;

    gray_count_tracker #(.DATA_WIDTH(4), .SYNC_STAGES(S), .EXT_WIDTH(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .gray_in    (gray_in),
        .bin_out    (bin_out),
        .ext_count  (ext_count),
        .step_valid (step_valid),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: values seen by the tracker are the gray_in samples from S edges earlier.
    int m_n;
    int hist[$];
    int m_bin, m_ext, m_errc, m_locked, m_step, m_wrap, m_errp;

    function automatic int enc(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    // Inverse by search over the encoding, deliberately unlike a bitwise decoder.
    function automatic int dec(input int g);
        for (int b = 0; b < 16; b++) begin
            if (enc(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int v, d;
        m_step = 0; m_wrap = 0; m_errp = 0;
        if (!resetn) begin
            m_n = 0; hist.delete();
            m_bin = 0; m_ext = 0; m_errc = 0; m_locked = 0;
        end else begin
            m_n++;
            hist.push_back(int'(gray_in));
            if (hist.size() > S) begin
                v = dec(hist.pop_front());
                if (m_n == S + 1) begin
                    m_bin = v; m_ext = v; m_locked = 1;
                end else begin
                    d = (v - m_bin) & 15;
                    if (d == 1) begin
                        m_step = 1;
                        m_wrap = (m_bin == 15) ? 1 : 0;
                        m_ext  = (m_ext + 1) & 16'hFFFF;
                        m_bin  = v;
                    end else if (d != 0) begin
                        m_errp = 1;
                        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                        m_bin  = v;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic rn, input int g);
        resetn  = rn;
        gray_in = 4'(g);
        @(posedge clk);
        model_step();
        #1;
        chk("model bin_out",    int'(bin_out),    m_bin);
        chk("model ext_count",  int'(ext_count),  m_ext);
        chk("model step_valid", int'(step_valid), m_step);
        chk("model wrap_pulse", int'(wrap_pulse), m_wrap);
        chk("model err_pulse",  int'(err_pulse),  m_errp);
        chk("model err_count",  int'(err_count),  m_errc);
        chk("model locked",     int'(locked),     m_locked);
    endtask

    typedef struct {
        logic       rn;
        logic [3:0] g;
        logic [3:0] bin;
        logic [15:0] ext;
        logic       step, wrap, errp;
        logic [7:0] errc;
        logic       lck;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int steps, wraps, errs, cur, r, wrap_bin, errc0;

        // rn, gray driven at this edge, expected outputs after it (tracker sees gray from 2 rows back)
        tbl[0]  = '{1'b0, 4'b0000, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b0001, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[4]  = '{1'b1, 4'b0011, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[5]  = '{1'b1, 4'b0011, 4'd1, 16'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[6]  = '{1'b1, 4'b0110, 4'd2, 16'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[7]  = '{1'b1, 4'b0110, 4'd2, 16'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[8]  = '{1'b1, 4'b0111, 4'd4, 16'd2, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[9]  = '{1'b1, 4'b0111, 4'd4, 16'd2, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[10] = '{1'b1, 4'b0101, 4'd5, 16'd3, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[11] = '{1'b1, 4'b0101, 4'd5, 16'd3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[12] = '{1'b1, 4'b0100, 4'd6, 16'd4, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[13] = '{1'b1, 4'b0100, 4'd6, 16'd4, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[14] = '{1'b1, 4'b0101, 4'd7, 16'd5, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[15] = '{1'b1, 4'b0101, 4'd7, 16'd5, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[16] = '{1'b1, 4'b0101, 4'd6, 16'd5, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1};
        tbl[17] = '{1'b1, 4'b0101, 4'd6, 16'd5, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1};
        tbl[18] = '{1'b0, 4'b0101, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};

        m_n = 0; m_bin = 0; m_ext = 0; m_errc = 0; m_locked = 0;
        m_step = 0; m_wrap = 0; m_errp = 0;

        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].rn, int'(tbl[i].g));
            chk($sformatf("tbl%0d bin_out", i),    int'(bin_out),    int'(tbl[i].bin));
            chk($sformatf("tbl%0d ext_count", i),  int'(ext_count),  int'(tbl[i].ext));
            chk($sformatf("tbl%0d step_valid", i), int'(step_valid), int'(tbl[i].step));
            chk($sformatf("tbl%0d wrap_pulse", i), int'(wrap_pulse), int'(tbl[i].wrap));
            chk($sformatf("tbl%0d err_pulse", i),  int'(err_pulse),  int'(tbl[i].errp));
            chk($sformatf("tbl%0d err_count", i),  int'(err_count),  int'(tbl[i].errc));
            chk($sformatf("tbl%0d locked", i),     int'(locked),     int'(tbl[i].lck));
        end

        // Acquire a non-zero value: 1100 decodes to 8.
        tick(1'b0, 'b1100);
        for (int i = 0; i < 3; i++) tick(1'b1, 'b1100);
        chk("acq8 bin_out", int'(bin_out), 8);
        chk("acq8 ext_count", int'(ext_count), 8);
        chk("acq8 locked", int'(locked), 1);
        chk("acq8 pulses", int'({step_valid, err_pulse}), 0);

        // Lock at 0, then count through 1..15, 0, 1 with one value every 3 cycles.
        tick(1'b0, 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 0);
        steps = 0; wraps = 0; errs = 0; wrap_bin = -1;
        for (int v = 1; v <= 17; v++) begin
            for (int k = 0; k < 3; k++) begin
                tick(1'b1, enc(v % 16));
                steps += int'(step_valid);
                errs  += int'(err_pulse);
                if (wrap_pulse) begin
                    wraps++;
                    wrap_bin = int'(bin_out);
                end
            end
        end
        chk("count steps", steps, 17);
        chk("count wraps", wraps, 1);
        chk("count wrap at zero", wrap_bin, 0);
        chk("count errs", errs, 0);
        chk("count ext_count", int'(ext_count), 17);
        chk("count bin_out", int'(bin_out), 1);
        chk("count err_count", int'(err_count), 0);

        // Jump 1 -> 4, then legal 4 -> 5.
        errs = 0; steps = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 'b0110);
            errs += int'(err_pulse); steps += int'(step_valid);
        end
        chk("jump err pulses", errs, 1);
        chk("jump steps", steps, 0);
        chk("jump err_count", int'(err_count), 1);
        chk("jump bin_out", int'(bin_out), 4);
        chk("jump ext_count", int'(ext_count), 17);
        steps = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 'b0111);
            steps += int'(step_valid);
        end
        chk("after jump steps", steps, 1);
        chk("after jump ext_count", int'(ext_count), 18);

        // Backward step 2 -> 1.
        for (int k = 0; k < 3; k++) tick(1'b1, 'b0011);
        errc0 = int'(err_count);
        errs = 0; steps = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 'b0001);
            errs += int'(err_pulse); steps += int'(step_valid);
        end
        chk("back err pulses", errs, 1);
        chk("back steps", steps, 0);
        chk("back err_count", int'(err_count), errc0 + 1);

        // 300 illegal jumps alternating binary 3 and 1, then saturation.
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            tick(1'b1, enc((k % 2 == 0) ? 3 : 1));
            errs += int'(err_pulse);
        end
        for (int k = 0; k < S; k++) begin
            tick(1'b1, enc(1));
            errs += int'(err_pulse);
        end
        chk("sat err pulses", errs, 300);
        chk("sat err_count", int'(err_count), 255);

        // One-edge reset mid-stream, then relock on the third edge.
        tick(1'b0, enc(2));
        chk("rst bin_out", int'(bin_out), 0);
        chk("rst ext_count", int'(ext_count), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst pulses", int'({step_valid, wrap_pulse, err_pulse}), 0);
        chk("rst locked", int'(locked), 0);
        tick(1'b1, enc(2));
        chk("relock e1", int'(locked), 0);
        tick(1'b1, enc(2));
        chk("relock e2", int'(locked), 0);
        tick(1'b1, enc(2));
        chk("relock e3", int'(locked), 1);
        chk("relock bin_out", int'(bin_out), 2);

        // Random traffic: mostly holds and +1 steps, some jumps and resets.
        cur = 2;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
            end else if (r < 88) begin
                cur = (cur + 1) % 16;
            end else begin
                cur = int'($urandom_range(0, 15));
            end
            tick(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, enc(cur));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
